// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax reduction PEs: mode/state encodings,
// clog2 and the per-mode accumulator identity value.
package softmax_pkg;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    // Sum starts from 0, max starts from the most negative value of the given width.
    function automatic logic signed [63:0] identity(input mode_e m, input int width);
        return (m == MODE_MAX) ? -(64'sd1 <<< (width - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/pe_reduce_tree.sv
// One-beat lane reduction (sum or signed max) through a binary tree, registered
// once with a valid bit that travels alongside the result.
module pe_reduce_tree
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  mode_e                                        mode,
    input  logic                                         valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0]                 in_data,
    output logic                                         valid_out,
    output logic signed [DATA_WIDTH+clog2(NUM_IN)-1:0]   result
);

    localparam int TREE_W = DATA_WIDTH + clog2(NUM_IN);

    // Heap-ordered nodes: leaves at NUM_IN..2*NUM_IN-1, root at 1; the extra
    // clog2(NUM_IN) bits keep the sum tree from ever overflowing.
    logic signed [TREE_W-1:0] node [1:2*NUM_IN-1];

    always_comb begin
        for (int i = 1; i < 2 * NUM_IN; i++) begin
            node[i] = '0;
        end
        for (int j = 0; j < NUM_IN; j++) begin
            node[NUM_IN+j] = TREE_W'($signed(in_data[j*DATA_WIDTH +: DATA_WIDTH]));
        end
        for (int i = NUM_IN - 1; i >= 1; i--) begin
            if (mode == MODE_MAX) begin
                node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
            end else begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            result    <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= node[1];
            end
        end
    end

endmodule

// File: rtl/pe_softmax_reduce.sv
// Frame-level softmax reduction PE: running max or exponent sum over frame_len beats.
// Define PE_SOFTMAX_SAT_EN for a saturating sum with a sticky ovf flag.
module pe_softmax_reduce
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           frame_len,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic                           busy,
    output logic                           ovf
);

    localparam int TREE_W = DATA_WIDTH + clog2(NUM_IN);

    state_e                      state_q, state_d;
    mode_e                       mode_q;
    logic [CNT_WIDTH-1:0]        frame_len_q;
    logic [CNT_WIDTH-1:0]        beat_cnt;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [TREE_W-1:0]    tree_q;
    logic signed [ACC_WIDTH-1:0] tree_ext;
    logic                        tree_valid;
    logic                        accept_start;
    logic                        beat_acc;
    logic                        last_beat;

    assign accept_start = (state_q == IDLE) && start && (frame_len != '0);
    assign in_ready     = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign beat_acc     = in_valid && in_ready;
    assign last_beat    = beat_acc && ((beat_cnt + CNT_WIDTH'(1)) == frame_len_q);
    assign tree_ext     = ACC_WIDTH'(tree_q);

    pe_reduce_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_q),
        .valid_in  (beat_acc),
        .in_data   (in_data),
        .valid_out (tree_valid),
        .result    (tree_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_start) state_d = RUN;
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef PE_SOFTMAX_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] sum_wide;
    logic               ovf_set;
    logic               ovf_q;
`endif

    // Accumulator next value; one guard bit detects sum overflow in the saturating build.
    always_comb begin
        acc_d = acc_q;
`ifdef PE_SOFTMAX_SAT_EN
        ovf_set  = 1'b0;
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {tree_ext[ACC_WIDTH-1], tree_ext};
`endif
        if (accept_start) begin
            acc_d = ACC_WIDTH'(identity(mode_e'(mode), ACC_WIDTH));
        end else if (tree_valid) begin
            if (mode_q == MODE_MAX) begin
                acc_d = (tree_ext > acc_q) ? tree_ext : acc_q;
            end else begin
`ifdef PE_SOFTMAX_SAT_EN
                if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
                    ovf_set = 1'b1;
                    acc_d   = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_d = sum_wide[ACC_WIDTH-1:0];
                end
`else
                acc_d = acc_q + tree_ext;
`endif
            end
        end
    end

`ifdef PE_SOFTMAX_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept_start) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_SUM;
            frame_len_q <= '0;
            beat_cnt    <= '0;
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            if (accept_start) begin
                mode_q      <= mode_e'(mode);
                frame_len_q <= frame_len;
                beat_cnt    <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // The result is captured on the first DONE cycle and held until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if ((state_q == DONE) && !out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
